// File: rtl/hist_frame_packer.sv
// Frames a stream of 32-bit histogram words as header, FRAME_LEN payload words and an optional checksum trailer.
// Define HIST_FRAME_CSUM_EN to append the two's-complement checksum trailer; otherwise tlast rides on the final payload word.
module hist_frame_packer #(
    parameter int          FRAME_LEN = 16,
    parameter logic [15:0] HDR_MAGIC = 16'hA55A
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] frame_count,
    output logic        busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HDR     = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;
`ifdef HIST_FRAME_CSUM_EN
    localparam logic [1:0] CSUM    = 2'd3;
`endif
    localparam logic [7:0] LEN8    = 8'(FRAME_LEN);

    logic [1:0]  state;
    logic [7:0]  beat_cnt;
    logic        out_hs;
    logic        in_hs;
    logic        last_word;
`ifdef HIST_FRAME_CSUM_EN
    logic [31:0] csum_acc;
`endif

    assign out_hs        = m_axis_tvalid & m_axis_tready;
    assign s_axis_tready = (state == PAYLOAD) & (!m_axis_tvalid | m_axis_tready);
    assign in_hs         = s_axis_tvalid & s_axis_tready;
    assign last_word     = (beat_cnt == LEN8 - 8'd1);
    assign busy          = (state != IDLE);

    // The output register drains first; any state action below that loads a new beat overrides the drain.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            beat_cnt      <= 8'd0;
            m_axis_tdata  <= 32'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            frame_count   <= 16'd0;
`ifdef HIST_FRAME_CSUM_EN
            csum_acc      <= 32'd0;
`endif
        end else begin
            if (out_hs) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                if (m_axis_tlast) begin
                    frame_count <= frame_count + 16'd1;
                end
            end

            case (state)
                IDLE: begin
                    // Wait for an empty register so the header carries the already-incremented sequence number.
                    if (s_axis_tvalid && !m_axis_tvalid) begin
                        m_axis_tdata  <= {HDR_MAGIC, frame_count[7:0], LEN8};
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        beat_cnt      <= 8'd0;
`ifdef HIST_FRAME_CSUM_EN
                        csum_acc      <= 32'd0;
`endif
                        state         <= HDR;
                    end
                end
                HDR: begin
                    if (out_hs) begin
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (in_hs) begin
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tvalid <= 1'b1;
                        beat_cnt      <= beat_cnt + 8'd1;
`ifdef HIST_FRAME_CSUM_EN
                        csum_acc      <= csum_acc + s_axis_tdata;
                        m_axis_tlast  <= 1'b0;
                        if (last_word) begin
                            state <= CSUM;
                        end
`else
                        m_axis_tlast  <= last_word;
                        if (last_word) begin
                            state <= IDLE;
                        end
`endif
                    end
                end
`ifdef HIST_FRAME_CSUM_EN
                CSUM: begin
                    // Only the trailer is ever loaded with tlast set, so tlast tells us it is already queued.
                    if (m_axis_tvalid && m_axis_tlast) begin
                        if (out_hs) begin
                            state <= IDLE;
                        end
                    end else if (!m_axis_tvalid || out_hs) begin
                        m_axis_tdata  <= 32'd0 - csum_acc;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hist_frame_packer.sv
// Self-checking bench for hist_frame_packer: three instances (FRAME_LEN 4, 1, 2) checked against a frame-level scoreboard.
// Builds for either setting of HIST_FRAME_CSUM_EN.
module tb_hist_frame_packer;

`ifdef HIST_FRAME_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif
    localparam int B0 = CSUM_ON ? 6 : 5;
    localparam int B1 = CSUM_ON ? 3 : 2;
    localparam int B2 = CSUM_ON ? 4 : 3;

    logic             aclk;
    logic             aresetn;
    logic [2:0][31:0] s_tdata;
    logic [2:0]       s_tvalid;
    logic [2:0]       s_tready;
    logic [2:0][31:0] m_tdata;
    logic [2:0]       m_tvalid;
    logic [2:0]       m_tready;
    logic [2:0]       m_tlast;
    logic [2:0][15:0] frame_count;
    logic [2:0]       busy;
    logic [2:0]       src_gate;

    logic [31:0] in_mem  [3][256];
    logic [32:0] exp_mem [3][256];
    logic [31:0] obs_data[3][256];
    logic        obs_last[3][256];
    int          obs_cyc [3][256];
    int          in_wr[3], in_rd[3], exp_wr[3], exp_rd[3], obs_n[3], model_fc[3], seq[3];
    logic [31:0] frame_words[16];
    int          n_checks, n_fail, cyc, base;

    hist_frame_packer #(.FRAME_LEN(4)) u_dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
        .m_axis_tlast(m_tlast[0]), .frame_count(frame_count[0]), .busy(busy[0]));

    hist_frame_packer #(.FRAME_LEN(1)) u_dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
        .m_axis_tlast(m_tlast[1]), .frame_count(frame_count[1]), .busy(busy[1]));

    hist_frame_packer #(.FRAME_LEN(2)) u_dut2 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata[2]), .s_axis_tvalid(s_tvalid[2]), .s_axis_tready(s_tready[2]),
        .m_axis_tdata(m_tdata[2]), .m_axis_tvalid(m_tvalid[2]), .m_axis_tready(m_tready[2]),
        .m_axis_tlast(m_tlast[2]), .frame_count(frame_count[2]), .busy(busy[2]));

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    always @(posedge aclk) cyc <= cyc + 1;

    function automatic int flen(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Queues n words for instance k and derives the beats the frame must produce.
    task automatic applyStimulus(input int k, input int n);
        logic [31:0] sum;
        bit          full;
        sum  = 32'd0;
        full = (n == flen(k));
        exp_mem[k][exp_wr[k]] = {1'b0, 16'hA55A, seq[k][7:0], 8'(flen(k))};
        exp_wr[k]++;
        for (int i = 0; i < n; i++) begin
            in_mem[k][in_wr[k]] = frame_words[i];
            in_wr[k]++;
            exp_mem[k][exp_wr[k]] = {(!CSUM_ON && full && i == n - 1), frame_words[i]};
            exp_wr[k]++;
            sum = sum + frame_words[i];
        end
        if (full && CSUM_ON) begin
            exp_mem[k][exp_wr[k]] = {1'b1, 32'd0 - sum};
            exp_wr[k]++;
        end
        if (full) seq[k]++;
    endtask

    task automatic driveSource(input int k);
        forever begin
            @(negedge aclk);
            if (src_gate[k] && in_rd[k] < in_wr[k]) begin
                s_tvalid[k] = 1'b1;
                s_tdata[k]  = in_mem[k][in_rd[k]];
            end else begin
                s_tvalid[k] = 1'b0;
                s_tdata[k]  = 32'd0;
            end
            #4;
            if (aresetn && s_tvalid[k] && s_tready[k]) in_rd[k]++;
        end
    endtask

    // Per-cycle compare, sampled 1 time unit before each rising edge.
    task automatic checkOutput(input int k);
        logic        prev_stall;
        logic [31:0] pd;
        logic        pl;
        prev_stall = 1'b0;
        pd = 32'd0;
        pl = 1'b0;
        forever begin
            @(negedge aclk);
            #4;
            if (!aresetn) begin
                check("rst_tvalid", m_tvalid[k], 0);
                check("rst_tlast", m_tlast[k], 0);
                check("rst_tdata", m_tdata[k], 0);
                check("rst_s_tready", s_tready[k], 0);
                check("rst_frame_count", frame_count[k], 0);
                check("rst_busy", busy[k], 0);
                model_fc[k] = 0;
                prev_stall  = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_tdata", m_tdata[k], pd);
                    check("stall_tvalid", m_tvalid[k], 1);
                    check("stall_tlast", m_tlast[k], pl);
                end
                if (m_tvalid[k] && !m_tready[k]) check("stall_s_tready", s_tready[k], 0);
                check("frame_count", frame_count[k], model_fc[k]);
                if (m_tvalid[k] && m_tready[k]) begin
                    check("exp_avail", exp_rd[k] < exp_wr[k], 1);
                    if (exp_rd[k] < exp_wr[k]) begin
                        check("beat_data", m_tdata[k], exp_mem[k][exp_rd[k]][31:0]);
                        check("beat_last", m_tlast[k], exp_mem[k][exp_rd[k]][32]);
                        exp_rd[k]++;
                    end
                    obs_data[k][obs_n[k]] = m_tdata[k];
                    obs_last[k][obs_n[k]] = m_tlast[k];
                    obs_cyc[k][obs_n[k]]  = cyc;
                    obs_n[k]++;
                    if (m_tlast[k]) model_fc[k]++;
                end
                prev_stall = m_tvalid[k] && !m_tready[k];
                pd = m_tdata[k];
                pl = m_tlast[k];
            end
        end
    endtask

    task automatic waitBeats(input int k, input int target);
        int c;
        c = 0;
        while (obs_n[k] < target && c < 200) begin
            @(negedge aclk);
            c++;
        end
        check($sformatf("beats_%0d", k), obs_n[k], target);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_proc
        initial driveSource(g);
        initial checkOutput(g);
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        for (int k = 0; k < 3; k++) begin
            in_wr[k] = 0; in_rd[k] = 0; exp_wr[k] = 0; exp_rd[k] = 0;
            obs_n[k] = 0; model_fc[k] = 0; seq[k] = 0;
        end
        s_tvalid = '0; s_tdata = '0; m_tready = 3'b111; src_gate = 3'b111;
        aresetn = 1'b1;
        #1 aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // First frame 1,2,3,4 on the FRAME_LEN=4 instance
        frame_words[0] = 32'd1; frame_words[1] = 32'd2; frame_words[2] = 32'd3; frame_words[3] = 32'd4;
        applyStimulus(0, 4);
        waitBeats(0, B0);
        check("f1_hdr", obs_data[0][0], 32'hA55A0004);
        for (int i = 1; i <= 4; i++) check($sformatf("f1_pay%0d", i), obs_data[0][i], i);
        if (CSUM_ON) check("f1_trailer", obs_data[0][5], 32'hFFFFFFF6);
        for (int i = 0; i < B0; i++) check($sformatf("f1_last%0d", i), obs_last[0][i], i == B0 - 1);
        check("f1_no_bubble", obs_cyc[0][B0-1] - obs_cyc[0][1], B0 - 2);
        repeat (2) @(negedge aclk);
        check("f1_frame_count", frame_count[0], 16'd1);
        check("f1_idle", busy[0], 0);

        // Identical second frame carries sequence byte 01
        applyStimulus(0, 4);
        waitBeats(0, 2 * B0);
        check("f2_hdr", obs_data[0][B0], 32'hA55A0104);
        repeat (2) @(negedge aclk);
        check("f2_frame_count", frame_count[0], 16'd2);

        // Downstream stall of 5 cycles on the second payload beat
        frame_words[0] = 32'h10; frame_words[1] = 32'h20; frame_words[2] = 32'h30; frame_words[3] = 32'h40;
        applyStimulus(0, 4);
        waitBeats(0, 2 * B0 + 2);
        m_tready[0] = 1'b0;
        repeat (3) @(negedge aclk);
        #4;
        check("stall_mid_data", m_tdata[0], 32'h20);
        check("stall_mid_valid", m_tvalid[0], 1);
        check("stall_mid_s_tready", s_tready[0], 0);
        repeat (2) @(negedge aclk);
        m_tready[0] = 1'b1;
        waitBeats(0, 3 * B0);
        check("stall_pay2", obs_data[0][2 * B0 + 2], 32'h20);
        check("stall_pay4", obs_data[0][2 * B0 + 4], 32'h40);
        repeat (2) @(negedge aclk);
        check("f3_frame_count", frame_count[0], 16'd3);

        // Source stops after two words, then reset discards the partial frame
        frame_words[0] = 32'd1; frame_words[1] = 32'd2;
        applyStimulus(0, 2);
        waitBeats(0, 3 * B0 + 3);
        repeat (3) @(negedge aclk);
        #4;
        check("wait_busy", busy[0], 1);
        check("wait_s_tready", s_tready[0], 1);
        check("wait_no_tvalid", m_tvalid[0], 0);
        @(negedge aclk);
        aresetn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_rd[k] = in_wr[k]; exp_rd[k] = exp_wr[k]; seq[k] = 0;
        end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        base = obs_n[0];
        frame_words[0] = 32'd1; frame_words[1] = 32'd2; frame_words[2] = 32'd3; frame_words[3] = 32'd4;
        applyStimulus(0, 4);
        waitBeats(0, base + B0);
        check("post_rst_hdr", obs_data[0][base], 32'hA55A0004);
        repeat (2) @(negedge aclk);
        check("post_rst_frame_count", frame_count[0], 16'd1);

        // FRAME_LEN=1 single word
        frame_words[0] = 32'hDEADBEEF;
        applyStimulus(1, 1);
        waitBeats(1, B1);
        check("fl1_hdr", obs_data[1][0], 32'hA55A0001);
        check("fl1_pay", obs_data[1][1], 32'hDEADBEEF);
        check("fl1_hdr_last", obs_last[1][0], 0);
        check("fl1_final_last", obs_last[1][B1-1], 1);
        if (CSUM_ON) check("fl1_trailer", obs_data[1][2], 32'h21524111);
        repeat (4) @(negedge aclk);
        check("fl1_beat_total", obs_n[1], B1);

        // Checksum wrap, then a back-to-back frame on FRAME_LEN=2
        frame_words[0] = 32'hFFFFFFFF; frame_words[1] = 32'h00000002;
        applyStimulus(2, 2);
        frame_words[0] = 32'h5; frame_words[1] = 32'h6;
        applyStimulus(2, 2);
        waitBeats(2, 2 * B2);
        check("fl2_hdr", obs_data[2][0], 32'hA55A0002);
        if (CSUM_ON) check("fl2_trailer", obs_data[2][3], 32'hFFFFFFFF);
        check("fl2_final_last", obs_last[2][B2-1], 1);
        check("fl2_hdr2", obs_data[2][B2], 32'hA55A0102);
        check("fl2_gap", obs_cyc[2][B2] > obs_cyc[2][B2-1] + 1, 1);
        repeat (2) @(negedge aclk);
        check("fl2_frame_count", frame_count[2], 16'd2);

        for (int k = 0; k < 3; k++) begin
            check($sformatf("drained_exp_%0d", k), exp_rd[k], exp_wr[k]);
            check($sformatf("drained_in_%0d", k), in_rd[k], in_wr[k]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
